// File: rtl/mb_pkg.sv
// Shared types and constants for the mb32-side memory path.
package mb_pkg;

    localparam int BYTES_PER_CELL = 4;
    localparam int ASZ_DEFAULT    = 17;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_CELL = 1'b1
    } sz_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DRAIN,
        ACK
    } br_state_e;

endpackage

// File: rtl/mb32_to_mb8_bridge.sv
// Serialises 32-bit cell / 8-bit byte requests into little-endian byte
// accesses on the mb8 memory port and reassembles read bytes into rdata.
module mb32_to_mb8_bridge
    import mb_pkg::*;
#(
    parameter int ASZ    = ASZ_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           we,
    input  logic           sz,
    input  logic [ASZ-1:0] addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic           ack,
    output logic           busy,
    output logic [ASZ-1:0] m_ai,
    output logic           m_we,
    output logic [7:0]     m_vi,
    input  logic [7:0]     m_vo
);

    localparam logic [1:0] LAST_CELL = 2'(BYTES_PER_CELL - 1);

    br_state_e      state, state_n;
    logic [1:0]     cnt, cnt_n, nxt;
    sz_e            sz_q;
    logic [ASZ-1:0] addr_q;
    logic [31:0]    wdata_q;
    logic           accept, last_issue;
    logic [ASZ-1:0] ai_n;
    logic           we_n;
    logic [7:0]     vi_n;

    // Read tracking pipe entry: {valid, last, lane}
    logic [3:0]     pipe [RD_LAT];
    logic           cap_valid, cap_last;
    logic [1:0]     cap_lane;
    logic [31:0]    col, col_n;

    assign ack        = (state == ACK);
    assign busy       = (state == WR) || (state == RD_ISSUE) || (state == RD_DRAIN);
    assign accept     = ((state == IDLE) || (state == ACK)) && req;
    assign last_issue = (cnt == ((sz_q == SZ_CELL) ? LAST_CELL : 2'd0));
    assign nxt        = cnt + 2'd1;
    assign {cap_valid, cap_last, cap_lane} = pipe[RD_LAT-1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ai_n    = m_ai;
        we_n    = 1'b0;
        vi_n    = m_vi;
        case (state)
            IDLE, ACK: begin
                if (req) begin
                    state_n = we ? WR : RD_ISSUE;
                    cnt_n   = '0;
                    ai_n    = addr;
                    we_n    = we;
                    if (we) vi_n = wdata[7:0];
                end else begin
                    state_n = IDLE;
                end
            end
            WR: begin
                if (last_issue) begin
                    state_n = ACK;
                end else begin
                    cnt_n = nxt;
                    ai_n  = addr_q + ASZ'(nxt);
                    we_n  = 1'b1;
                    vi_n  = wdata_q[{nxt, 3'b000} +: 8];
                end
            end
            RD_ISSUE: begin
                if (last_issue) begin
                    state_n = RD_DRAIN;
                end else begin
                    cnt_n = nxt;
                    ai_n  = addr_q + ASZ'(nxt);
                end
            end
            RD_DRAIN: begin
                if (cap_valid && cap_last) state_n = ACK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            m_ai    <= '0;
            m_we    <= 1'b0;
            m_vi    <= '0;
            sz_q    <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            m_ai  <= ai_n;
            m_we  <= we_n;
            m_vi  <= vi_n;
            if (accept) begin
                sz_q   <= sz_e'(sz);
                addr_q <= addr;
                if (we) wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        col_n = col;
        col_n[{cap_lane, 3'b000} +: 8] = m_vo;
    end

    // Capture side runs RD_LAT cycles behind issue, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) pipe[i] <= '0;
            col   <= '0;
            rdata <= '0;
        end else begin
            pipe[0] <= {(state == RD_ISSUE), last_issue, cnt};
            for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) pipe[i] <= pipe[i-1];
            if (accept)         col <= '0;
            else if (cap_valid) col <= col_n;
            if (cap_valid && cap_last) rdata <= col_n;
        end
    end

endmodule

// File: tb/tb_mb32_to_mb8_bridge.sv
// Bench for mb32_to_mb8_bridge: RD_LAT=1 and RD_LAT=2 instances, byte memory
// models, a shadow memory for expected reads and a cycle model for ack/busy.
module tb_mb32_to_mb8_bridge;

    logic        clk = 1'b0;
    logic [1:0]  rst, req, we, sz, ack, busy, m_we;
    logic [16:0] addr [2];
    logic [16:0] m_ai [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [7:0]  m_vi [2];
    logic [7:0]  m_vo [2];

    logic [7:0]  mem [2][131072];
    logic [7:0]  sh  [2][131072];
    logic [7:0]  rd0, rd1a, rd1b;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [16:0] aiq [$];
    logic [31:0] drv_last [2];
    int          left [2];
    bit          ackc [2];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mb32_to_mb8_bridge #(.ASZ(17), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .sz(sz[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]),
        .busy(busy[0]), .m_ai(m_ai[0]), .m_we(m_we[0]), .m_vi(m_vi[0]),
        .m_vo(m_vo[0])
    );

    mb32_to_mb8_bridge #(.ASZ(17), .RD_LAT(2)) u_dut_l2 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .sz(sz[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]),
        .busy(busy[1]), .m_ai(m_ai[1]), .m_we(m_we[1]), .m_vi(m_vi[1]),
        .m_vo(m_vo[1])
    );

    // Byte memories: write on edge, read data valid RD_LAT cycles after address
    always @(posedge clk) begin
        if (m_we[0]) mem[0][m_ai[0]] <= m_vi[0];
        if (m_we[1]) mem[1][m_ai[1]] <= m_vi[1];
        rd0  <= mem[0][m_ai[0]];
        rd1a <= mem[1][m_ai[1]];
        rd1b <= rd1a;
    end
    assign m_vo[0] = rd0;
    assign m_vo[1] = rd1b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] sb_pop(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Cycle model: left = cycles until ack cycle; 0 means idle or ack cycle
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                if (left[k] != 0) void'(sb_pop(k));
                left[k] = 0;
                ackc[k] = 1'b0;
            end else if (left[k] == 0 && req[k]) begin
                left[k] = (sz[k] ? 4 : 1) + (we[k] ? 0 : k + 1);
                ackc[k] = 1'b0;
            end else if (left[k] != 0) begin
                left[k]--;
                ackc[k] = (left[k] == 0);
            end else begin
                ackc[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(ackc[k]));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(left[k] != 0));
            if (ackc[k]) begin
                if (sb_size(k) == 0) chk($sformatf("sb_underflow%0d", k), 32'd1, 32'd0);
                else chk($sformatf("rdata%0d", k), rdata[k], sb_pop(k));
            end
        end
        if (m_we[0]) aiq.push_back(m_ai[0]);
    end

    task automatic wait_free(input int k);
        for (int t = 0; t < 40 && left[k] != 0; t++) begin
            @(posedge clk); #1;
        end
        if (left[k] != 0) chk("free_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_ack(input int k, output int c);
        for (int t = 0; t < 40 && !ackc[k]; t++) begin
            @(posedge clk); #1;
        end
        if (!ackc[k]) chk("ack_timeout", 32'd1, 32'd0);
        c = cyc;
    endtask

    function automatic logic [31:0] shadow_rd(input int k, input logic s, input logic [16:0] a);
        logic [31:0] e = '0;
        for (int i = 0; i < (s ? 4 : 1); i++) e[8*i +: 8] = sh[k][a + 17'(i)];
        return e;
    endfunction

    // Drives one request while the model is free; returns one cycle into it.
    task automatic do_op(input int k, input logic w, input logic s,
                         input logic [16:0] a, input logic [31:0] d);
        logic [31:0] e;
        wait_free(k);
        if (w) begin
            for (int i = 0; i < (s ? 4 : 1); i++) sh[k][a + 17'(i)] = d[8*i +: 8];
            e = drv_last[k];
        end else begin
            e = shadow_rd(k, s, a);
            drv_last[k] = e;
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        req[k] = 1'b1; we[k] = w; sz[k] = s; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        logic [16:0] exp_ai [4];
        for (int i = 0; i < 131072; i++) begin
            mem[0][i] = '0; mem[1][i] = '0; sh[0][i] = '0; sh[1][i] = '0;
        end
        rst = 2'b11; req = '0; we = '0; sz = '0;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; wdata[k] = '0; drv_last[k] = '0; left[k] = 0; ackc[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = '0;
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_m_ai", 32'(m_ai[0]), 32'h0);
        chk("rst_m_vi", 32'(m_vi[0]), 32'h0);
        chk("rst_m_we", 32'(m_we[0]), 32'h0);

        // Cell write then cell read, memory contents little-endian
        do_op(0, 1'b1, 1'b1, 17'h00100, 32'h44332211);
        do_op(0, 1'b0, 1'b1, 17'h00100, 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mem100_%0d", i), 32'(mem[0][17'h100 + 17'(i)]), 32'(8'h11 * (i + 1)));

        // Byte write, byte read, unaligned cell read
        do_op(0, 1'b1, 1'b0, 17'h00200, 32'hFFFF_FFA5);
        do_op(0, 1'b0, 1'b0, 17'h00200, 32'h0);
        do_op(0, 1'b0, 1'b1, 17'h001FF, 32'h0);

        // Cell write wrapping past top of address space
        wait_free(0);
        aiq.delete();
        do_op(0, 1'b1, 1'b1, 17'h1FFFE, 32'hDEADBEEF);
        wait_free(0);
        exp_ai[0] = 17'h1FFFE; exp_ai[1] = 17'h1FFFF; exp_ai[2] = 17'h00000; exp_ai[3] = 17'h00001;
        chk("wrap_count", 32'(aiq.size()), 32'd4);
        for (int i = 0; i < 4 && i < aiq.size(); i++)
            chk($sformatf("wrap_ai%0d", i), 32'(aiq[i]), 32'(exp_ai[i]));
        do_op(0, 1'b0, 1'b1, 17'h1FFFE, 32'h0);

        // Back-to-back cell reads with req held through the first ack
        wait_free(0);
        q0.push_back(shadow_rd(0, 1'b1, 17'h00100));
        req[0] = 1'b1; we[0] = 1'b0; sz[0] = 1'b1; addr[0] = 17'h00100;
        @(posedge clk); #1;
        drv_last[0] = shadow_rd(0, 1'b1, 17'h1FFFE);
        q0.push_back(drv_last[0]);
        addr[0] = 17'h1FFFE;
        wait_ack(0, t1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_ack(0, t2);
        chk("b2b_gap", 32'(t2 - t1), 32'd6);

        // Reset in c2 of a cell write: only bytes 0 and 1 land
        do_op(0, 1'b1, 1'b1, 17'h00300, 32'hCAFEF00D);
        sh[0][17'h302] = 8'h00; sh[0][17'h303] = 8'h00;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        drv_last[0] = '0;
        chk("midrst_m_we", 32'(m_we[0]), 32'h0);
        chk("midrst_rdata", rdata[0], 32'h0);
        chk("midrst_busy", 32'(busy[0]), 32'h0);
        do_op(0, 1'b0, 1'b1, 17'h00300, 32'h0);
        do_op(0, 1'b0, 1'b0, 17'h00302, 32'h0);

        // RD_LAT=2 instance with junk on the request fields mid-transaction
        do_op(1, 1'b1, 1'b1, 17'h00040, 32'h87654321);
        do_op(1, 1'b0, 1'b1, 17'h00040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            req[1] = 1'($urandom_range(1)); we[1] = 1'($urandom_range(1));
            sz[1] = 1'($urandom_range(1)); addr[1] = 17'($urandom);
            wdata[1] = $urandom;
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        do_op(1, 1'b0, 1'b0, 17'h00042, 32'h0);
        do_op(1, 1'b0, 1'b1, 17'h00041, 32'h0);

        wait_free(0);
        wait_free(1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_left0", 32'(q0.size()), 32'd0);
        chk("sb_left1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mb32_to_mb8_bridge.md
Name: mb32_to_mb8_bridge

Overview:
Cell/byte access sequencer sitting directly upstream of the 8-bit single-port 128K byte memory on the mb8 bus. It accepts 32-bit cell or 8-bit byte read/write requests from the eForth1 core on a req/ack handshake. It serialises each request into byte accesses on the memory side, little-endian, and for reads reassembles the returned bytes into a 32-bit result.

Parameters:
ASZ, 17, byte address width on both sides (128K bytes).
RD_LAT, 1, memory read latency in cycles from address driven to data valid on m_vo; legal values 1 or 2.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req  in  1  request valid; held by master until ack
we  in  1  1 = write, 0 = read; sampled at accept
sz  in  1  0 = byte, 1 = cell (4 bytes); sampled at accept
addr  in  ASZ  start byte address; sampled at accept
wdata  in  32  write data; byte access uses wdata[7:0]; sampled at accept
rdata  out  32  read result; valid in ack cycle, held until next accept
ack  out  1  one-cycle completion pulse
busy  out  1  high from cycle after accept through cycle before ack
m_ai  out  ASZ  memory byte address, registered
m_we  out  1  memory write enable, registered
m_vi  out  8  memory write data, registered
m_vo  in  8  memory read data

Behaviour:
- Reset: the state machine goes to IDLE. ack=0, busy=0, rdata=0, m_ai=0, m_we=0, m_vi=0, byte counter=0.
- Reset mid-transaction: at the next edge all outputs take their reset values. No ack is issued and the pending transaction is dropped. m_we must be low in the cycle after rst is sampled.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN, ACK.
- Accept: at the rising edge ending cycle c0, if state=IDLE and req=1, the bridge latches we, sz and addr, and latches wdata when we=1. Byte count N is 4 when sz=1 and 1 when sz=0.
- Byte i (i=0..N-1) address is (addr+i) mod 2^ASZ. No alignment is required, and the address wraps silently past 0x1FFFF.
- Lane order: byte i maps to data bits [8i+7:8i] (little-endian).
- Write: in cycles c1..cN, m_ai is byte i, m_we=1, and m_vi is wdata lane i. In cycle cN+1, m_we=0 and ack=1.
  - Byte write: ack in c2. Cell write: ack in c5.
- Read: in cycles c1..cN, m_ai is byte i and m_we=0 (RD_ISSUE). Byte i is sampled from m_vo at the end of cycle c(i+1+RD_LAT) into lane i (RD_DRAIN covers the tail). ack=1 in the cycle after the last sample.
  - With RD_LAT=1: byte read ack in c3, cell read ack in c6.
  - rdata is updated at the last-sample edge. Unfilled lanes of a byte read are 0 (zero-extended).
- Sample tracking uses an RD_LAT-deep shift register of {valid, lane}, so the capture stage is independent of the issue stage.
- busy=1 from c1 until the cycle before ack. busy=0 in the ack cycle and in IDLE.
- req is sampled only in IDLE or ACK. The ACK state behaves as IDLE for acceptance: if req=1 in the ack cycle, a new transaction is accepted at that edge, giving back-to-back operation with no bubble. The master must drop req in the ack cycle if it has nothing further.
- req or field changes while busy are ignored.
- When not writing, m_ai holds its last value and m_vi holds its last value; only m_we is forced to 0.
- rdata is unchanged by write transactions.

Decomposition:
- Shared package mb_pkg:
  - typedef sz_e {SZ_BYTE=0, SZ_CELL=1}
  - state enum br_state_e
  - constants BYTES_PER_CELL=4 and ASZ_DEFAULT=17
  - these are reused by the mb32-side memory blocks
- No sub-module is needed. The read-capture shift register and lane collector stay inline as one always_ff block plus the FSM.

Test Plan:
- Cell write 0x44332211 @0x00100, then cell read @0x00100 -> memory bytes 100..103 = 11,22,33,44; write ack in c5; rdata=0x44332211 with ack in c6.
- Byte write 0xA5 @0x00200, then byte read @0x00200 and cell read @0x001FF -> byte rdata=0x000000A5; cell rdata has 0xA5 in lane 1.
- Cell write 0xDEADBEEF @0x1FFFE -> m_ai sequence 1FFFE, 1FFFF, 00000, 00001; readback=0xDEADBEEF.
- req held high across two cell reads -> second accept in first ack cycle; ack pulses exactly 6 cycles apart; busy low only in ack cycles.
- rst asserted in c2 of a cell write -> m_we=0 from c3; no ack; bytes addr+2 and addr+3 unchanged; a following read works normally.
- RD_LAT=2 build, cell read -> ack in c7, correct lane ordering; req toggled and fields changed mid-transaction have no effect.
